fpmul_apb_sequencer: RTL and testbench
======================================

# fpmul_apb_sequencer

APB slave that sequences a multi-cycle IEEE754 single-precision multiplier core on behalf of the 8-bit m6502 CPU. It occupies a free APB peripheral port and runs on the CPU/APB clock. It assembles the 32-bit operands from byte writes, issues a one-cycle start pulse to the core, and supervises completion with a timeout. It captures the result, exposes byte-readable status and result registers, and stalls reads of the result with `pready` while a multiply is in flight.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in WAIT before the operation is aborted; range 1..65535.
- `clk`  in  1: APB clock (the CPU clock domain); all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `paddr`  in  32: APB address; only `paddr[3:0]` is decoded (byte address).
- `psel`  in  1: APB select.
- `penable`  in  1: APB access phase.
- `pwrite`  in  1: 1 = write, 0 = read.
- `pwdata`  in  32: write data; only `[7:0]` is used.
- `pready`  out  1: transfer complete.
- `prdata`  out  32: read data; `[31:8]` are always 0.
- `fpm_start`  out  1: one-cycle start pulse to the multiplier core.
- `fpm_op_a`, `fpm_op_b`  out  32 each: operands, held stable for the whole operation.
- `fpm_done`  in  1: core result valid; single-cycle pulse.
- `fpm_res`  in  32: core product.
- `irq`  out  1: level interrupt, equal to `DONE & IE`.

## Operation
- Register map (byte addresses):
  - 0x0–0x3: OPA bytes, little-endian, R/W.
  - 0x4–0x7: OPB bytes, R/W.
  - 0x8: CTRL, W. bit0 = GO (self-clearing, reads as 0); bit1 = IE (R/W).
  - 0x9: STATUS, R/W1C. bit0 = BUSY (read-only); bit1 = DONE; bit2 = TMO; bit3 = OVR.
  - 0xC–0xF: RES bytes, R.
  - Other addresses: reads return 0; writes are ignored.
- A write takes effect in the access cycle (`psel & penable & pwrite`).
- Writes to OPA/OPB while BUSY are ignored and set OVR.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH on a CTRL write with GO=1. DONE and TMO are cleared in the same cycle.
  - LAUNCH → WAIT unconditionally; `fpm_start` is 1 only while in LAUNCH.
  - WAIT → IDLE when `fpm_done`=1: RES ← `fpm_res`, DONE ← 1.
  - WAIT → IDLE when the cycle counter reaches TIMEOUT_CYCLES-1 with no `fpm_done`: TMO ← 1, RES unchanged.
- BUSY = (state != IDLE).
- GO written while BUSY: ignored, OVR ← 1, operation unaffected.
- `fpm_done` is ignored outside WAIT.
- Timeout counter: 16-bit; cleared on entry to WAIT; increments on each WAIT cycle; saturates, never wraps.
- Same-cycle W1C clear and hardware set of DONE/TMO: the set wins.
- `fpm_op_a`/`fpm_op_b` are driven directly from OPA/OPB.
- Reset (at any time, including mid-operation):
  - state IDLE; OPA, OPB, RES, IE, DONE, TMO, OVR, counter all 0.
  - Next cycle outputs: `fpm_start`=0, `irq`=0, `pready`=1, `prdata`=0.
  - A `fpm_done` arriving after reset is ignored.

## Timing
- Writes have zero wait states: `pready`=1 in the access cycle.
- Reads of non-RES addresses have zero wait states. `prdata` is combinational from `paddr`/registers during the access phase and 0 otherwise.
- Read of RES while BUSY: `pready`=0 from the access cycle until the cycle after the FSM returns to IDLE. Then `pready`=1 with the new RES (or the old RES after a timeout). APB inputs are held stable by the master.
- Cycle latencies for a CTRL GO write in access cycle T:
  - T+1: LAUNCH, `fpm_start`=1, BUSY=1.
  - T+2: WAIT begins.
  - `fpm_done` sampled high at cycle D: at D+1, RES is valid, DONE=1, BUSY=0, `irq`=IE.
  - Minimum GO-to-DONE latency is therefore 3 cycles.
- Timeout: TMO=1 exactly TIMEOUT_CYCLES cycles after entering WAIT.
- A back-to-back GO is accepted in the first IDLE cycle.

## Test plan
- Reset mid-WAIT: `rst` for one cycle → state IDLE, `fpm_start`=0, STATUS=0x00, `irq`=0. A late `fpm_done` produces no DONE.
- Basic multiply: OPA=0x3FC00000 (1.5), OPB=0x40000000 (2.0), GO. Core model returns 0x40400000 after 5 cycles → `fpm_start` high for exactly 1 cycle at T+1; RES bytes read 0x00,0x00,0x40,0x40; STATUS=0x02.
- Stalled read: read 0xF immediately after GO, core latency 10 → `pready` low until the FSM returns to IDLE, then `prdata`=0x40 with `pready`=1.
- Timeout: TIMEOUT_CYCLES=8, core never asserts `fpm_done` → STATUS=0x04 exactly 8 cycles after entering WAIT; RES unchanged.
- Overrun: GO and OPA writes while BUSY → operands seen by the core unchanged, STATUS bit3=1. Writing 0x08 to STATUS clears OVR.
- Interrupt and clear race: IE=1 → `irq`=1 on DONE. A W1C of DONE in the same cycle as a new completion leaves DONE=1. A subsequent W1C drops `irq` the next cycle.

Source files
------------

// File: rtl/fpmul_apb_sequencer.sv
// rtl/fpmul_apb_sequencer.sv - APB byte-wide front end that launches and supervises a multi-cycle FP32 multiplier
module fpmul_apb_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        fpm_start,
    output logic [31:0] fpm_op_a,
    output logic [31:0] fpm_op_b,
    input  logic        fpm_done,
    input  logic [31:0] fpm_res,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [31:0] opa_q, opb_q, res_q;
    logic [15:0] cnt_q;
    logic        ie_q, done_q, tmo_q, ovr_q, start_q;

    logic        busy, wr_en, rd_en;
    logic [3:0]  addr;
    logic [1:0]  byte_sel;
    logic [7:0]  wbyte;
    logic [7:0]  rbyte;
    logic        unused_bits;

    assign addr        = paddr[3:0];
    assign byte_sel    = paddr[1:0];
    assign wbyte       = pwdata[7:0];
    assign busy        = (state_q != IDLE);
    assign wr_en       = psel & penable & pwrite;
    assign rd_en       = psel & penable & ~pwrite;
    assign unused_bits = ^{paddr[31:4], pwdata[31:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (wr_en) begin
                case (addr)
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        if (busy) ovr_q <= 1'b1;
                        else      opa_q[8*byte_sel +: 8] <= wbyte;
                    end
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        if (busy) ovr_q <= 1'b1;
                        else      opb_q[8*byte_sel +: 8] <= wbyte;
                    end
                    4'h8: begin
                        ie_q <= wbyte[1];
                        if (wbyte[0]) begin
                            if (busy) begin
                                ovr_q <= 1'b1;
                            end else begin
                                state_q <= LAUNCH;
                                start_q <= 1'b1;
                                done_q  <= 1'b0;
                                tmo_q   <= 1'b0;
                            end
                        end
                    end
                    4'h9: begin
                        if (wbyte[1]) done_q <= 1'b0;
                        if (wbyte[2]) tmo_q  <= 1'b0;
                        if (wbyte[3]) ovr_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Placed after the register writes so a completion beats a same-cycle W1C.
            case (state_q)
                LAUNCH: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (fpm_done) begin
                        res_q   <= fpm_res;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (cnt_q != 16'hFFFF) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rbyte = 8'h00;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3: rbyte = opa_q[8*byte_sel +: 8];
            4'h4, 4'h5, 4'h6, 4'h7: rbyte = opb_q[8*byte_sel +: 8];
            4'h8:                   rbyte = {6'b0, ie_q, 1'b0};
            4'h9:                   rbyte = {4'b0, ovr_q, tmo_q, done_q, busy};
            4'hC, 4'hD, 4'hE, 4'hF: rbyte = res_q[8*byte_sel +: 8];
            default:                rbyte = 8'h00;
        endcase
    end

    // Result reads hold the bus until the in-flight multiply has retired.
    assign pready    = ~(rd_en & (addr[3:2] == 2'b11) & busy);
    assign prdata    = rd_en ? {24'h0, rbyte} : 32'h0;
    assign fpm_start = start_q;
    assign fpm_op_a  = opa_q;
    assign fpm_op_b  = opb_q;
    assign irq       = done_q & ie_q;

endmodule

// File: tb/tb_fpmul_apb_sequencer.sv
// tb/tb_fpmul_apb_sequencer.sv - directed self-checking bench for fpmul_apb_sequencer
module tb_fpmul_apb_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] paddr = '0;
    logic        psel_a = 1'b0, psel_t = 1'b0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready_a, pready_t;
    logic [31:0] prdata_a, prdata_t;
    logic        start_a, start_t;
    logic [31:0] opa_a, opb_a, opa_t, opb_t;
    logic        done_a = 1'b0, done_t = 1'b0;
    logic [31:0] res_a = '0, res_t = '0;
    logic        irq_a, irq_t;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpmul_apb_sequencer dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_a), .prdata(prdata_a),
        .fpm_start(start_a), .fpm_op_a(opa_a), .fpm_op_b(opb_a),
        .fpm_done(done_a), .fpm_res(res_a), .irq(irq_a)
    );

    fpmul_apb_sequencer #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_t), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready_t), .prdata(prdata_t),
        .fpm_start(start_t), .fpm_op_a(opa_t), .fpm_op_b(opb_t),
        .fpm_done(done_t), .fpm_res(res_t), .irq(irq_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input bit t, input logic [3:0] a, input logic [7:0] d);
        psel_a = ~t; psel_t = t; paddr = {28'h0, a}; pwrite = 1'b1; pwdata = {24'h0, d}; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1;
        chk("write pready", {31'h0, t ? pready_t : pready_a}, 32'h1);
        tick();
        psel_a = 1'b0; psel_t = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input bit t, input logic [3:0] a, input logic [7:0] exp, input string tag);
        psel_a = ~t; psel_t = t; paddr = {28'h0, a}; pwrite = 1'b0; penable = 1'b0;
        tick();
        penable = 1'b1;
        #1;
        chk({tag, " pready"}, {31'h0, t ? pready_t : pready_a}, 32'h1);
        chk(tag, t ? prdata_t : prdata_a, {24'h0, exp});
        tick();
        psel_a = 1'b0; psel_t = 1'b0; penable = 1'b0;
    endtask

    initial begin
        int lowcnt;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst start", {31'h0, start_a}, 32'h0);
        chk("rst irq", {31'h0, irq_a}, 32'h0);
        chk("rst pready", {31'h0, pready_a}, 32'h1);
        chk("rst prdata", prdata_a, 32'h0);
        chk("rst opa", opa_a, 32'h0);
        apb_read(0, 4'h9, 8'h00, "rst status");

        // Basic multiply: 1.5 * 2.0
        apb_write(0, 4'h0, 8'h00); apb_write(0, 4'h1, 8'h00);
        apb_write(0, 4'h2, 8'hC0); apb_write(0, 4'h3, 8'h3F);
        apb_write(0, 4'h4, 8'h00); apb_write(0, 4'h5, 8'h00);
        apb_write(0, 4'h6, 8'h00); apb_write(0, 4'h7, 8'h40);
        chk("op_a", opa_a, 32'h3FC00000);
        chk("op_b", opb_a, 32'h40000000);
        apb_read(0, 4'h2, 8'hC0, "opa byte2");
        apb_write(0, 4'h8, 8'h01);
        chk("start T+1", {31'h0, start_a}, 32'h1);
        tick();
        chk("start T+2", {31'h0, start_a}, 32'h0);
        tick(); tick(); tick();
        done_a = 1'b1; res_a = 32'h40400000;
        tick();
        done_a = 1'b0; res_a = 32'hDEADBEEF;
        apb_read(0, 4'hC, 8'h00, "res byte0");
        apb_read(0, 4'hD, 8'h00, "res byte1");
        apb_read(0, 4'hE, 8'h40, "res byte2");
        apb_read(0, 4'hF, 8'h40, "res byte3");
        apb_read(0, 4'h9, 8'h02, "status done");
        chk("irq ie0", {31'h0, irq_a}, 32'h0);

        // Stalled read of RES byte 3, core latency 10
        apb_write(0, 4'h8, 8'h01);
        psel_a = 1'b1; paddr = 32'hF; pwrite = 1'b0; penable = 1'b0;
        tick();
        penable = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!pready_a) lowcnt++;
            if (i == 9) begin done_a = 1'b1; res_a = 32'h40900000; end
            tick();
        end
        done_a = 1'b0;
        #1;
        chk("stall cycles", lowcnt, 32'd10);
        chk("stall pready", {31'h0, pready_a}, 32'h1);
        chk("stall prdata", prdata_a, 32'h40);
        tick();
        psel_a = 1'b0; penable = 1'b0;
        apb_read(0, 4'hE, 8'h90, "stall res byte2");

        // Overrun: OPA and GO writes while busy
        apb_write(0, 4'h8, 8'h01);
        apb_write(0, 4'h0, 8'hFF);
        apb_write(0, 4'h8, 8'h01);
        chk("ovr op_a", opa_a, 32'h3FC00000);
        apb_read(0, 4'h9, 8'h09, "ovr status busy");
        done_a = 1'b1; res_a = 32'h40400000;
        tick();
        done_a = 1'b0;
        apb_read(0, 4'h9, 8'h0A, "ovr status done");
        apb_write(0, 4'h9, 8'h08);
        apb_read(0, 4'h9, 8'h02, "ovr cleared");
        apb_read(0, 4'h0, 8'h00, "ovr opa byte0");

        // Interrupt and clear race
        apb_write(0, 4'h8, 8'h02);
        chk("irq on", {31'h0, irq_a}, 32'h1);
        apb_read(0, 4'h8, 8'h02, "ctrl ie");
        apb_write(0, 4'h8, 8'h03);
        chk("irq go clears", {31'h0, irq_a}, 32'h0);
        psel_a = 1'b1; paddr = 32'h9; pwrite = 1'b1; pwdata = 32'h02; penable = 1'b0;
        tick();
        penable = 1'b1; done_a = 1'b1; res_a = 32'h3F800000;
        tick();
        psel_a = 1'b0; penable = 1'b0; pwrite = 1'b0; done_a = 1'b0;
        chk("race irq", {31'h0, irq_a}, 32'h1);
        apb_read(0, 4'h9, 8'h02, "race status");
        apb_write(0, 4'h9, 8'h02);
        chk("irq w1c", {31'h0, irq_a}, 32'h0);

        // Reset mid-WAIT, then a late completion
        apb_write(0, 4'h8, 8'h03);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst start", {31'h0, start_a}, 32'h0);
        chk("midrst irq", {31'h0, irq_a}, 32'h0);
        chk("midrst op_a", opa_a, 32'h0);
        done_a = 1'b1; res_a = 32'h12345678;
        tick();
        done_a = 1'b0;
        apb_read(0, 4'h9, 8'h00, "midrst status");
        apb_read(0, 4'hF, 8'h00, "midrst res byte3");

        // Timeout instance: one good result, then two runs with no completion
        apb_write(1, 4'h8, 8'h01);
        tick();
        done_t = 1'b1; res_t = 32'hA5A5A5A5;
        tick();
        done_t = 1'b0;
        apb_read(1, 4'h9, 8'h02, "tmo pre status");
        apb_write(1, 4'h8, 8'h01);
        repeat (7) tick();
        apb_read(1, 4'h9, 8'h01, "tmo wait+7 busy");
        apb_write(1, 4'h8, 8'h01);
        repeat (8) tick();
        apb_read(1, 4'h9, 8'h04, "tmo wait+8");
        apb_read(1, 4'hC, 8'hA5, "tmo res kept");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
